// File: rtl/fn_sw_descrambler.sv
// Serial XOR descrambler: recovers a from y = a ^ b using a local PRBS7 keystream
// that restarts from SEED on every accepted start-of-frame bit; one-entry registered output.
module fn_sw_descrambler #(
    parameter logic [6:0]  SEED  = 7'h7F,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic             in_sof,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             out_sof,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [6:0]       lfsr_reg, lfsr_next;
    logic [6:0]       eff_state;
    logic             data_reg, data_next;
    logic             sof_reg, sof_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept, transfer, key_bit;

    assign out_valid = (state_reg == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    // A start-of-frame bit is descrambled with the SEED state itself, not the running state.
    assign eff_state = in_sof ? SEED : lfsr_reg;
    assign key_bit   = eff_state[6] ^ eff_state[5];

    assign out_data = data_reg;
    assign out_sof  = sof_reg;
    assign bit_cnt  = cnt_reg;

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        data_next  = data_reg;
        sof_next   = sof_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE:    if (accept) state_next = HOLD;
            HOLD:    if (transfer && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The LFSR steps on every accept, bypassed or not, to stay aligned with the transmitter.
        if (accept) begin
            lfsr_next = {eff_state[5:0], key_bit};
            data_next = sel ? (in_data ^ key_bit) : in_data;
            sof_next  = in_sof;
            if (sel && (cnt_reg != '1)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            lfsr_reg  <= SEED;
            data_reg  <= 1'b0;
            sof_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            data_reg  <= data_next;
            sof_reg   <= sof_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_fn_sw_descrambler.sv
// Randomized scoreboard bench for fn_sw_descrambler; a second instance with a 4-bit
// counter shares the stimulus to exercise counter saturation.
module tb_fn_sw_descrambler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_data = 1'b0, in_sof = 1'b0, sel = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_data, out_sof;
    logic [15:0] bit_cnt;
    logic        in_ready_s, out_valid_s, out_data_s, out_sof_s;
    logic [3:0]  bit_cnt_s;

    fn_sw_descrambler #(.SEED(7'h7F), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof), .bit_cnt(bit_cnt)
    );

    fn_sw_descrambler #(.SEED(7'h7F), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_sof(in_sof), .sel(sel), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_sof(out_sof_s), .bit_cnt(bit_cnt_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference keystream: bit sequence b seeded from SEED (MSB first), b[n+7] = b[n] ^ b[n+1];
    // the keystream bit for position n of a frame is b[n+7]. Period 127.
    logic [6:0] seed_v = 7'h7F;
    bit         bseq[134];
    bit         ks[127];
    initial begin
        for (int i = 0; i < 7; i++) bseq[i] = seed_v[6-i];
        for (int i = 7; i < 134; i++) bseq[i] = bseq[i-7] ^ bseq[i-6];
        for (int i = 0; i < 127; i++) ks[i] = bseq[i+7];
    end

    // Reference model, evaluated at each rising edge
    typedef struct { bit d; bit s; } exp_t;
    exp_t exp_q[$];
    bit   m_valid = 0;
    int   pos = 0;
    int   m_cnt = 0;

    always @(posedge clk) begin
        bit acc, xfer;
        int p;
        if (!rst_n) begin
            exp_q.delete();
            m_valid = 0;
            pos     = 0;
            m_cnt   = 0;
        end else begin
            acc  = in_valid && (!m_valid || out_ready);
            xfer = m_valid && out_ready;
            if (acc) begin
                exp_t e;
                p   = in_sof ? 0 : pos;
                e.d = sel ? (in_data ^ ks[p]) : in_data;
                e.s = in_sof;
                exp_q.push_back(e);
                pos = (p + 1) % 127;
                if (sel) m_cnt++;
                m_valid = 1;
            end else if (xfer) begin
                m_valid = 0;
            end
        end
    end

    // Monitor: compares on the falling edge, pops on each output transfer
    bit cap[$];
    always @(negedge clk) begin
        chk("in_ready", in_ready, (!m_valid || out_ready));
        chk("in_ready_s", in_ready_s, (!m_valid || out_ready));
        chk("out_valid", out_valid, m_valid);
        chk("bit_cnt", bit_cnt, m_cnt & 32'hFFFF);
        chk("bit_cnt_sat", bit_cnt_s, (m_cnt > 15) ? 15 : m_cnt);
        if (m_valid && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_sof", out_sof, exp_q[0].s);
                if (out_ready) begin
                    cap.push_back(out_data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = random back-pressure, 2 = forced value
    int   bp_mode = 0;
    logic force_val = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0)      out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                   out_ready = force_val;
    end

    task automatic send(input logic d, input logic s, input logic sl);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_sof = s; sel = sl;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (!m_valid || out_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b11111101;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Frame 1: sel=1, all-ones input
        cap.delete();
        for (int i = 0; i < 8; i++) send(1'b1, (i == 0), 1'b1);
        idle(3);
        if (cap.size() < 8) chk("frame1_len", cap.size(), 8);
        else for (int i = 0; i < 8; i++) chk("frame1_pattern", cap[i], pat[7-i]);
        chk("frame1_cnt", bit_cnt, 8);
        $display("frame1 done, bit_cnt=%0d", bit_cnt);

        // Frame 2 bypassed, then sel=1 continuing mid-sequence
        for (int i = 0; i < 8; i++) send(1'b1, (i == 0), 1'b0);
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 1'b1);
        idle(2);
        $display("bypass/resume done, bit_cnt=%0d", bit_cnt);

        // Back-pressure: hold out_ready low three cycles with a bit waiting
        bp_mode = 2; force_val = 1'b0;
        idle(1);
        send(1'b1, 1'b1, 1'b1);
        fork
            send(1'b1, 1'b0, 1'b1);
            begin repeat (3) @(posedge clk); force_val = 1'b1; end
        join
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 1'b1);
        bp_mode = 0;
        idle(2);
        $display("back-pressure done");

        // Mid-frame restart after 5 bits
        for (int i = 0; i < 5; i++) send(1'b1, (i == 0), 1'b1);
        for (int i = 0; i < 8; i++) send(1'b1, (i == 0), 1'b1);
        idle(2);
        $display("mid-frame sof done");

        // Saturation of the 4-bit counter instance
        for (int i = 0; i < 20; i++) send($urandom_range(0, 1), 1'b0, 1'b1);
        idle(2);
        chk("cnt4_saturated", bit_cnt_s, 4'hF);
        $display("saturation done, bit_cnt_s=%0h", bit_cnt_s);

        // Random traffic with random back-pressure and gaps
        bp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send($urandom_range(0, 1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end
        bp_mode = 0;
        idle(3);
        $display("random traffic done, checks=%0d", checks);

        // Synchronous reset while holding a bit
        bp_mode = 2; force_val = 1'b0;
        idle(1);
        send(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_bit_cnt", bit_cnt, 0);
        bp_mode = 0;
        idle(1);
        cap.delete();
        send(1'b1, 1'b0, 1'b1);
        idle(2);
        if (cap.size() < 1) chk("post_reset_len", cap.size(), 1);
        else chk("post_reset_seed_bit", cap[0], 1);
        $display("sync reset done");

        // Pulse between edges must not reset anything
        bp_mode = 2; force_val = 1'b0;
        idle(1);
        send(1'b1, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("glitch_out_valid", out_valid, 1);
        chk("glitch_bit_cnt_nonzero", (bit_cnt != 0), 1);
        force_val = 1'b1;
        idle(1);
        bp_mode = 0;
        for (int i = 0; i < 10; i++) send($urandom_range(0, 1), 1'b0, 1'b1);
        idle(3);
        $display("async pulse done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
